// File: rtl/genius_input_checker.sv
// Player-input checker for the Genius game: compares debounced button presses
// against the stored sequence and reports progress, pass, fail and timeout.
module genius_input_checker #(
   parameter int MAX_LEN        = 16,
   parameter int TIMEOUT_CYCLES = 150_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] seq_len,
   input  logic [3:0] btn,
   output logic [3:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic       busy,
   output logic       pass,
   output logic       fail,
   output logic       timeout,
   output logic [4:0] progress,
   output logic [3:0] led
);

   localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    LEN_MAX = 5'(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE
   } state_t;

   state_t        state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [4:0]    len, len_d;
   logic [4:0]    progress_d;
   logic          pass_d, fail_d, timeout_d;
   logic [3:0]    btn_q;
   logic [3:0]    led_d;
   logic          one_hot;
   logic          valid_press;
   logic [1:0]    symbol;
   logic [4:0]    eff_len;

   assign busy    = (state != IDLE);
   assign rd_addr = progress[3:0];

   always_comb begin
      one_hot     = (btn != '0) && ((btn & (btn - 4'd1)) == '0);
      valid_press = (btn_q == '0) && one_hot;
      symbol      = 2'd0;
      if (btn[1]) symbol = 2'd1;
      if (btn[2]) symbol = 2'd2;
      if (btn[3]) symbol = 2'd3;
      eff_len = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
   end

   always_comb begin
      state_d    = state;
      timer_d    = timer;
      len_d      = len;
      progress_d = progress;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               progress_d = '0;
               timer_d    = '0;
               len_d      = eff_len;
               if (eff_len == '0) pass_d  = 1'b1;
               else               state_d = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            // A valid press wins over a timer expiring in the same cycle.
            if (valid_press) begin
               if (symbol == rd_data) begin
                  progress_d = progress + 5'd1;
                  state_d    = WAIT_RELEASE;
               end else begin
                  fail_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (timer == T_LAST) begin
               fail_d    = 1'b1;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         WAIT_RELEASE: begin
            if (btn == '0) begin
               if (progress == len) begin
                  pass_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  timer_d = '0;
                  state_d = WAIT_PRESS;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      led_d = (state_d != IDLE) ? btn : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         len      <= '0;
         progress <= '0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         timeout  <= 1'b0;
         btn_q    <= '0;
         led      <= '0;
      end else begin
         state    <= state_d;
         timer    <= timer_d;
         len      <= len_d;
         progress <= progress_d;
         pass     <= pass_d;
         fail     <= fail_d;
         timeout  <= timeout_d;
         btn_q    <= btn;
         led      <= led_d;
      end
   end

endmodule

// File: tb/tb_genius_input_checker.sv
// Directed bench for genius_input_checker: a cycle-level behavioural model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_genius_input_checker;

   localparam int T   = 20;
   localparam int MAX = 16;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [4:0] seq_len;
   logic [3:0] btn;
   logic [3:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy, pass, fail, timeout;
   logic [4:0] progress;
   logic [3:0] led;

   logic [1:0] mem [MAX];

   int n_vec = 0;
   int n_bad = 0;
   int pass_cnt = 0, fail_cnt = 0, to_cnt = 0;

   // behavioural model state
   bit         m_busy, m_rel, m_pass, m_fail, m_to;
   int         m_prog, m_len, m_wait;
   logic [3:0] m_led, m_btnq;

   genius_input_checker #(.MAX_LEN(MAX), .TIMEOUT_CYCLES(T)) dut (
      .clock(clk), .reset(reset), .start(start), .seq_len(seq_len), .btn(btn),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .pass(pass),
      .fail(fail), .timeout(timeout), .progress(progress), .led(led)
   );

   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int sym_of(input logic [3:0] b);
      for (int i = 0; i < 4; i++) if (b[i]) return i;
      return 0;
   endfunction

   task automatic model_step();
      bit valid;
      m_pass = 0; m_fail = 0; m_to = 0;
      if (reset) begin
         m_busy = 0; m_rel = 0; m_prog = 0; m_len = 0; m_wait = 0;
         m_led = '0; m_btnq = '0;
         return;
      end
      valid = (m_btnq == 0) && ($countones(btn) == 1);
      if (!m_busy) begin
         if (start) begin
            m_len  = (seq_len > MAX) ? MAX : int'(seq_len);
            m_prog = 0;
            if (m_len == 0) m_pass = 1;
            else begin m_busy = 1; m_rel = 0; m_wait = 0; end
         end
      end else if (!m_rel) begin
         if (valid) begin
            if (sym_of(btn) == int'(mem[m_prog % MAX])) begin m_prog++; m_rel = 1; end
            else begin m_fail = 1; m_busy = 0; end
         end else if (m_wait == T - 1) begin
            m_fail = 1; m_to = 1; m_busy = 0;
         end else m_wait++;
      end else if (btn == 0) begin
         if (m_prog == m_len) begin m_pass = 1; m_busy = 0; end
         else begin m_rel = 0; m_wait = 0; end
      end
      m_led  = m_busy ? btn : 4'd0;
      m_btnq = btn;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("busy", busy, m_busy);
      chk("pass", pass, m_pass);
      chk("fail", fail, m_fail);
      chk("timeout", timeout, m_to);
      chk("progress", progress, m_prog);
      chk("rd_addr", rd_addr, m_prog % MAX);
      chk("led", led, m_led);
      chk("pass_and_fail", int'(pass && fail), 0);
      chk("timeout_without_fail", int'(timeout && !fail), 0);
      if (pass) pass_cnt++;
      if (fail) fail_cnt++;
      if (timeout) to_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int len);
      seq_len = 5'(len);
      start   = 1'b1;
      cyc(1);
      start   = 1'b0;
   endtask

   task automatic press(input int sym);
      btn = 4'b0001 << sym;
      cyc(2);
      btn = '0;
      cyc(2);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   initial begin
      int p0, f0, k;
      bit seen;
      reset = 1'b1; start = 1'b0; seq_len = '0; btn = '0;
      for (int i = 0; i < MAX; i++) mem[i] = 2'd0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      cyc(2);
      chk("reset_busy", busy, 0);
      chk("reset_progress", progress, 0);
      chk("reset_led", led, 0);
      reset = 1'b0;
      cyc(2);

      // correct run with a stray start while busy
      p0 = pass_cnt; f0 = fail_cnt;
      do_start(3);
      chk("run_busy", busy, 1);
      press(2);
      chk("run_prog1", progress, 1);
      start = 1'b1; seq_len = 5'd1; cyc(1); start = 1'b0;
      press(0);
      chk("run_prog2", progress, 2);
      btn = 4'b1000; cyc(2); btn = '0; cyc(1);
      chk("run_pass_pulse", pass, 1);
      chk("run_busy_end", busy, 0);
      chk("run_prog3", progress, 3);
      cyc(2);
      chk("run_pass_count", pass_cnt - p0, 1);
      chk("run_fail_count", fail_cnt - f0, 0);

      // wrong symbol
      do_start(3);
      press(2);
      btn = 4'b0010; cyc(1);
      chk("wrong_fail", fail, 1);
      chk("wrong_timeout", timeout, 0);
      chk("wrong_busy", busy, 0);
      chk("wrong_prog", progress, 1);
      btn = '0; cyc(3);

      // timeout: fail seen after the 21st edge from the start edge
      p0 = pass_cnt;
      seq_len = 5'd3; start = 1'b1; k = 0; seen = 0;
      cyc(1); start = 1'b0; k = 1;
      while (!seen && k < 40) begin
         if (fail) seen = 1;
         else begin cyc(1); k++; end
      end
      chk("timeout_latency", k, 21);
      chk("timeout_flag", timeout, 1);
      chk("timeout_no_pass", pass_cnt - p0, 0);
      cyc(2);

      // multi-press and held button: only the final 0100 counts
      do_start(3);
      btn = 4'b0011; cyc(2);
      btn = 4'b0001; cyc(2);
      chk("multi_ignored", progress, 0);
      btn = '0; cyc(2);
      btn = 4'b0100; cyc(2);
      chk("multi_prog", progress, 1);
      chk("multi_led", led, 4'b0100);
      btn = '0; cyc(2);

      // reset mid-run after two matches
      do_reset();
      p0 = pass_cnt; f0 = fail_cnt;
      do_start(3);
      press(2);
      press(0);
      chk("mid_prog2", progress, 2);
      reset = 1'b1; cyc(1); reset = 1'b0;
      chk("mid_prog0", progress, 0);
      chk("mid_busy", busy, 0);
      cyc(3);
      chk("mid_no_pass", pass_cnt - p0, 0);
      chk("mid_no_fail", fail_cnt - f0, 0);

      // zero length
      do_start(0);
      chk("zero_pass", pass, 1);
      chk("zero_busy", busy, 0);
      cyc(1);
      chk("zero_pass_once", pass, 0);

      // seq_len above capacity saturates to 16
      for (int i = 0; i < MAX; i++) mem[i] = 2'((i * 3 + 1) % 4);
      p0 = pass_cnt;
      do_start(20);
      for (int i = 0; i < MAX - 1; i++) press((i * 3 + 1) % 4);
      chk("sat_prog15", progress, 15);
      btn = 4'b0001 << ((15 * 3 + 1) % 4); cyc(2); btn = '0; cyc(1);
      chk("sat_pass", pass, 1);
      chk("sat_prog16", progress, 16);
      cyc(2);
      chk("sat_pass_count", pass_cnt - p0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
